// File: rtl/cache_axi_mux_if.sv
// Bundled AXI4-style channel handshakes for one side of cache_axi_mux.
// N ports packed per signal; R/B id, payload and last are broadcast.
interface cache_axi_mux_if #(
   parameter int N   = 1,
   parameter int IdW = 4,
   parameter int ArW = 64,
   parameter int AwW = 64,
   parameter int WW  = 72,
   parameter int RW  = 66,
   parameter int BW  = 2
);
   logic [N-1:0]     ar_valid;
   logic [N-1:0]     ar_ready;
   logic [N*IdW-1:0] ar_id;
   logic [N*ArW-1:0] ar;
   logic [N-1:0]     aw_valid;
   logic [N-1:0]     aw_ready;
   logic [N*IdW-1:0] aw_id;
   logic [N*AwW-1:0] aw;
   logic [N-1:0]     w_valid;
   logic [N-1:0]     w_ready;
   logic [N*WW-1:0]  w;
   logic [N-1:0]     w_last;
   logic [N-1:0]     r_valid;
   logic [N-1:0]     r_ready;
   logic [IdW-1:0]   r_id;
   logic [RW-1:0]    r;
   logic             r_last;
   logic [N-1:0]     b_valid;
   logic [N-1:0]     b_ready;
   logic [IdW-1:0]   b_id;
   logic [BW-1:0]    b;

   modport master (
      output ar_valid, ar_id, ar,
      input  ar_ready,
      output aw_valid, aw_id, aw,
      input  aw_ready,
      output w_valid, w, w_last,
      input  w_ready,
      input  r_valid, r_id, r, r_last,
      output r_ready,
      input  b_valid, b_id, b,
      output b_ready
   );

   modport slave (
      input  ar_valid, ar_id, ar,
      output ar_ready,
      input  aw_valid, aw_id, aw,
      output aw_ready,
      input  w_valid, w, w_last,
      output w_ready,
      output r_valid, r_id, r, r_last,
      input  r_ready,
      output b_valid, b_id, b,
      input  b_ready
   );
endinterface

// File: rtl/cache_axi_mux.sv
// N:1 AXI4 mux for L1 cache masters: RR AR/AW arbitration, W index FIFO, ID-prefix R/B routing.
// Optional per-input outstanding limit: define CACHE_AXI_MUX_TRACK_EN.
module cache_axi_mux #(
   parameter int NumInp     = 3,
   parameter int IdWidth    = 4,
   parameter int ArWidth    = 64,
   parameter int AwWidth    = 64,
   parameter int WWidth     = 72,
   parameter int RWidth     = 66,
   parameter int BWidth     = 2,
   parameter int WFifoDepth = 4,
   parameter int MaxTxn     = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   cache_axi_mux_if.slave    s_bus,
   cache_axi_mux_if.master   m_bus,
   output logic              dec_err_o,
   output logic [NumInp-1:0] busy_o
);
   localparam int SelW   = $clog2(NumInp);
   localparam int OutIdW = IdWidth + SelW;
   localparam int PtrW   = (WFifoDepth > 1) ? $clog2(WFifoDepth) : 1;
   localparam int CntW   = $clog2(WFifoDepth + 1);
   localparam logic [SelW:0] NumSel = (SelW+1)'(NumInp);

   // {found, index}: first requester at or after ptr
   function automatic logic [SelW:0] rr_pick(
      input logic [NumInp-1:0] req,
      input logic [SelW-1:0]   ptr
   );
      logic [SelW:0]   res;
      logic [SelW-1:0] jj;
      int              j;
      res = '0;
      for (int k = NumInp - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= NumInp) j = j - NumInp;
         jj = j[SelW-1:0];
         if (req[jj]) res = {1'b1, jj};
      end
      return res;
   endfunction

   function automatic logic [SelW-1:0] sel_inc(input logic [SelW-1:0] s);
      return (s == SelW'(NumInp - 1)) ? '0 : s + 1'b1;
   endfunction

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(WFifoDepth - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [NumInp-1:0] w_blk;
   logic [NumInp-1:0] w_busy;

   // AR arbiter
   logic            r_ar_lock;
   logic [SelW-1:0] r_ar_sel;
   logic [SelW-1:0] r_ar_ptr;
   logic [SelW:0]   w_ar_pick;
   logic            w_ar_gnt;
   logic [SelW-1:0] w_ar_sel;
   logic            w_ar_hs;

   assign w_ar_pick      = rr_pick(s_bus.ar_valid & ~w_blk, r_ar_ptr);
   assign w_ar_gnt       = r_ar_lock | w_ar_pick[SelW];
   assign w_ar_sel       = r_ar_lock ? r_ar_sel : w_ar_pick[SelW-1:0];
   assign m_bus.ar_valid = w_ar_gnt & ~rst_i;
   assign m_bus.ar_id    = {w_ar_sel, s_bus.ar_id[w_ar_sel*IdWidth +: IdWidth]};
   assign m_bus.ar       = s_bus.ar[w_ar_sel*ArWidth +: ArWidth];
   assign w_ar_hs        = m_bus.ar_valid & m_bus.ar_ready;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ar_lock <= 1'b0;
         r_ar_sel  <= '0;
         r_ar_ptr  <= '0;
      end else begin
         r_ar_lock <= w_ar_gnt & ~w_ar_hs;
         r_ar_sel  <= w_ar_sel;
         if (w_ar_hs) r_ar_ptr <= sel_inc(w_ar_sel);
      end
   end

   // AW arbiter, additionally held off while the W index FIFO is full
   logic            r_aw_lock;
   logic [SelW-1:0] r_aw_sel;
   logic [SelW-1:0] r_aw_ptr;
   logic [SelW:0]   w_aw_pick;
   logic            w_aw_gnt;
   logic [SelW-1:0] w_aw_sel;
   logic            w_aw_hs;
   logic            w_wf_full;
   logic            w_wf_empty;

   assign w_aw_pick      = rr_pick(s_bus.aw_valid & ~w_blk, r_aw_ptr);
   assign w_aw_gnt       = r_aw_lock | w_aw_pick[SelW];
   assign w_aw_sel       = r_aw_lock ? r_aw_sel : w_aw_pick[SelW-1:0];
   assign m_bus.aw_valid = w_aw_gnt & ~w_wf_full & ~rst_i;
   assign m_bus.aw_id    = {w_aw_sel, s_bus.aw_id[w_aw_sel*IdWidth +: IdWidth]};
   assign m_bus.aw       = s_bus.aw[w_aw_sel*AwWidth +: AwWidth];
   assign w_aw_hs        = m_bus.aw_valid & m_bus.aw_ready;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_aw_lock <= 1'b0;
         r_aw_sel  <= '0;
         r_aw_ptr  <= '0;
      end else begin
         r_aw_lock <= w_aw_gnt & ~w_aw_hs;
         r_aw_sel  <= w_aw_sel;
         if (w_aw_hs) r_aw_ptr <= sel_inc(w_aw_sel);
      end
   end

   // W index FIFO
   logic [SelW-1:0] r_wf_mem [WFifoDepth];
   logic [PtrW-1:0] r_wf_rd;
   logic [PtrW-1:0] r_wf_wr;
   logic [CntW-1:0] r_wf_cnt;
   logic [SelW-1:0] w_wf_head;
   logic            w_wf_pop;

   assign w_wf_full     = (r_wf_cnt == CntW'(WFifoDepth));
   assign w_wf_empty    = (r_wf_cnt == '0);
   assign w_wf_head     = r_wf_mem[r_wf_rd];
   assign m_bus.w_valid = ~w_wf_empty & s_bus.w_valid[w_wf_head] & ~rst_i;
   assign m_bus.w       = s_bus.w[w_wf_head*WWidth +: WWidth];
   assign m_bus.w_last  = s_bus.w_last[w_wf_head];
   assign w_wf_pop      = m_bus.w_valid & m_bus.w_ready & m_bus.w_last;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < WFifoDepth; k++) r_wf_mem[k] <= '0;
         r_wf_rd  <= '0;
         r_wf_wr  <= '0;
         r_wf_cnt <= '0;
      end else begin
         if (w_aw_hs) begin
            r_wf_mem[r_wf_wr] <= w_aw_sel;
            r_wf_wr           <= ptr_inc(r_wf_wr);
         end
         if (w_wf_pop) r_wf_rd <= ptr_inc(r_wf_rd);
         if (w_aw_hs && !w_wf_pop) r_wf_cnt <= r_wf_cnt + 1'b1;
         else if (!w_aw_hs && w_wf_pop) r_wf_cnt <= r_wf_cnt - 1'b1;
      end
   end

   // R/B demux on the inserted prefix
   logic [SelW-1:0] w_r_pre;
   logic [SelW-1:0] w_b_pre;
   logic            w_r_ok;
   logic            w_b_ok;
   logic            r_dec_err;

   assign w_r_pre = m_bus.r_id[OutIdW-1 -: SelW];
   assign w_b_pre = m_bus.b_id[OutIdW-1 -: SelW];
   assign w_r_ok  = ({1'b0, w_r_pre} < NumSel);
   assign w_b_ok  = ({1'b0, w_b_pre} < NumSel);

   assign s_bus.r_id    = m_bus.r_id[IdWidth-1:0];
   assign s_bus.r       = m_bus.r;
   assign s_bus.r_last  = m_bus.r_last;
   assign s_bus.b_id    = m_bus.b_id[IdWidth-1:0];
   assign s_bus.b       = m_bus.b;
   assign m_bus.r_ready = ~rst_i & (~w_r_ok | s_bus.r_ready[w_r_pre]);
   assign m_bus.b_ready = ~rst_i & (~w_b_ok | s_bus.b_ready[w_b_pre]);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_dec_err <= 1'b0;
      else r_dec_err <= (m_bus.r_valid & ~w_r_ok) | (m_bus.b_valid & ~w_b_ok);
   end

   assign dec_err_o = r_dec_err;

   logic [NumInp-1:0] w_s_ar_rdy;
   logic [NumInp-1:0] w_s_aw_rdy;
   logic [NumInp-1:0] w_s_w_rdy;
   logic [NumInp-1:0] w_s_r_vld;
   logic [NumInp-1:0] w_s_b_vld;

   for (genvar gi = 0; gi < NumInp; gi++) begin : g_port
      assign w_s_ar_rdy[gi] = w_ar_hs & (w_ar_sel == SelW'(gi));
      assign w_s_aw_rdy[gi] = w_aw_hs & (w_aw_sel == SelW'(gi));
      assign w_s_w_rdy[gi]  = ~w_wf_empty & m_bus.w_ready & ~rst_i &
                              (w_wf_head == SelW'(gi));
      assign w_s_r_vld[gi]  = m_bus.r_valid & ~rst_i & (w_r_pre == SelW'(gi));
      assign w_s_b_vld[gi]  = m_bus.b_valid & ~rst_i & (w_b_pre == SelW'(gi));
   end

   assign s_bus.ar_ready = w_s_ar_rdy;
   assign s_bus.aw_ready = w_s_aw_rdy;
   assign s_bus.w_ready  = w_s_w_rdy;
   assign s_bus.r_valid  = w_s_r_vld;
   assign s_bus.b_valid  = w_s_b_vld;

`ifdef CACHE_AXI_MUX_TRACK_EN
   // one spare count: an AR and AW of one input can both land at MaxTxn-1
   localparam int TW = $clog2(MaxTxn + 2);

   for (genvar gi = 0; gi < NumInp; gi++) begin : g_trk
      logic [TW-1:0] r_cnt;
      logic          w_inc_ar;
      logic          w_inc_aw;
      logic          w_dec_r;
      logic          w_dec_b;

      assign w_inc_ar = w_s_ar_rdy[gi];
      assign w_inc_aw = w_s_aw_rdy[gi];
      assign w_dec_r  = w_s_r_vld[gi] & m_bus.r_ready & m_bus.r_last;
      assign w_dec_b  = w_s_b_vld[gi] & m_bus.b_ready;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) r_cnt <= '0;
         else r_cnt <= r_cnt + TW'(w_inc_ar) + TW'(w_inc_aw)
                       - TW'(w_dec_r) - TW'(w_dec_b);
      end

      assign w_blk[gi]  = (r_cnt >= TW'(MaxTxn));
      assign w_busy[gi] = (r_cnt != '0);
   end
`else
   localparam bit TxnOk = (MaxTxn >= 1);

   assign w_blk  = {NumInp{~TxnOk}};
   assign w_busy = '0;
`endif

   assign busy_o = w_busy;
endmodule

// File: tb/tb_cache_axi_mux.sv
// Directed bench for cache_axi_mux (NumInp=3, IdWidth=4, WFifoDepth=4).
// Define CACHE_AXI_MUX_TRACK_EN for the outstanding-limit section.
module tb_cache_axi_mux;
`ifdef CACHE_AXI_MUX_TRACK_EN
   localparam int MAX_TXN = 2;
`else
   localparam int MAX_TXN = 8;
`endif

   logic       clk;
   logic       rst;
   logic       dec_err;
   logic [2:0] busy;
   int         n_chk;
   int         n_err;
   logic [71:0] wpl [3];

   cache_axi_mux_if #(.N(3), .IdW(4), .ArW(64), .AwW(64),
                      .WW(72), .RW(66), .BW(2)) s_if ();
   cache_axi_mux_if #(.N(1), .IdW(6), .ArW(64), .AwW(64),
                      .WW(72), .RW(66), .BW(2)) m_if ();

   cache_axi_mux #(
      .NumInp(3), .IdWidth(4), .ArWidth(64), .AwWidth(64),
      .WWidth(72), .RWidth(66), .BWidth(2),
      .WFifoDepth(4), .MaxTxn(MAX_TXN)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .s_bus    (s_if),
      .m_bus    (m_if),
      .dec_err_o(dec_err),
      .busy_o   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      wpl[0] = 72'hF0_0000_0000_0000_00A0;
      wpl[1] = 72'hF0_0000_0000_0000_00A1;
      wpl[2] = 72'hF0_0000_0000_0000_00A2;
      s_if.ar_valid = '0; s_if.ar_id = '0; s_if.ar = '0;
      s_if.aw_valid = '0; s_if.aw_id = '0; s_if.aw = '0;
      s_if.w_valid = '0; s_if.w = '0; s_if.w_last = '0;
      s_if.r_ready = '0; s_if.b_ready = '0;
      m_if.ar_ready = '0; m_if.aw_ready = '0; m_if.w_ready = '0;
      m_if.r_valid = '0; m_if.r_id = '0; m_if.r = '0; m_if.r_last = 1'b0;
      m_if.b_valid = '0; m_if.b_id = '0; m_if.b = '0;
      rst = 1'b1;

      // everything requesting while held in reset
      @(negedge clk);
      s_if.ar_valid = 3'b111; s_if.aw_valid = 3'b111; s_if.w_valid = 3'b111;
      s_if.r_ready = 3'b111; s_if.b_ready = 3'b111;
      m_if.ar_ready = 1'b1; m_if.aw_ready = 1'b1; m_if.w_ready = 1'b1;
      m_if.r_valid = 1'b1; m_if.b_valid = 1'b1;
      #1;
      chk("rst_m_ar_valid", m_if.ar_valid, 0);
      chk("rst_m_aw_valid", m_if.aw_valid, 0);
      chk("rst_m_w_valid", m_if.w_valid, 0);
      chk("rst_s_ar_ready", s_if.ar_ready, 0);
      chk("rst_s_aw_ready", s_if.aw_ready, 0);
      chk("rst_s_w_ready", s_if.w_ready, 0);
      chk("rst_s_r_valid", s_if.r_valid, 0);
      chk("rst_s_b_valid", s_if.b_valid, 0);
      chk("rst_m_r_ready", m_if.r_ready, 0);
      chk("rst_m_b_ready", m_if.b_ready, 0);
      chk("rst_dec_err", dec_err, 0);
      chk("rst_busy", busy, 0);

      @(negedge clk);
      rst = 1'b0;
      s_if.ar_valid = '0; s_if.aw_valid = '0; s_if.w_valid = '0;
      s_if.r_ready = '0; s_if.b_ready = '0;
      m_if.ar_ready = '0; m_if.aw_ready = '0; m_if.w_ready = '0;
      m_if.r_valid = '0; m_if.b_valid = '0;
      #1;
      chk("idle_m_ar_valid", m_if.ar_valid, 0);
      chk("idle_dec_err", dec_err, 0);
      chk("idle_busy", busy, 0);

      // AR: three simultaneous requests granted 0,1,2
      @(negedge clk);
      s_if.ar_id = 12'hCBA;
      s_if.ar = {64'hA2, 64'hA1, 64'hA0};
      m_if.ar_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         s_if.ar_valid = 3'b111 << i;
         #1;
         chk("ar_valid", m_if.ar_valid, 1);
         chk("ar_id", m_if.ar_id, (i << 4) | (10 + i));
         chk("ar_payload", m_if.ar, 64'hA0 + i);
         chk("ar_s_ready", s_if.ar_ready, 3'b001 << i);
      end
      @(negedge clk);
      s_if.ar_valid = '0;
      #1;
      chk("ar_idle", m_if.ar_valid, 0);
      m_if.ar_ready = 1'b0;
      do_reset();

      // AW: grant to input 1 held while m_aw_ready is low
      @(negedge clk);
      s_if.aw_id = 12'h750;
      s_if.aw = {64'hBBBB, 64'hAAAA, 64'h0};
      s_if.aw_valid = 3'b010;
      m_if.aw_ready = 1'b1;
      #1;
      chk("aw_first_ready", s_if.aw_ready, 3'b010);
      chk("aw_first_id", m_if.aw_id, 6'h15);
      @(negedge clk);
      m_if.aw_ready = 1'b0;
      #1;
      chk("aw_hold_valid", m_if.aw_valid, 1);
      chk("aw_hold_id0", m_if.aw_id, 6'h15);
      @(negedge clk);
      s_if.aw_valid = 3'b110;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("aw_lock_id", m_if.aw_id, 6'h15);
         chk("aw_lock_payload", m_if.aw, 64'hAAAA);
         chk("aw_lock_s_ready", s_if.aw_ready, 3'b000);
         @(negedge clk);
      end
      m_if.aw_ready = 1'b1;
      #1;
      chk("aw_rel_ready", s_if.aw_ready, 3'b010);
      chk("aw_rel_id", m_if.aw_id, 6'h15);
      @(negedge clk);
      s_if.aw_valid = 3'b100;
      #1;
      chk("aw_next_id", m_if.aw_id, 6'h27);
      chk("aw_next_ready", s_if.aw_ready, 3'b100);
      @(negedge clk);
      s_if.aw_valid = '0;
      m_if.aw_ready = 1'b0;
      #1;
      chk("aw_idle", m_if.aw_valid, 0);

      // W: FIFO holds 1,1,2 -> single-beat bursts in that order
      @(negedge clk);
      s_if.w = {wpl[2], wpl[1], wpl[0]};
      s_if.w_valid = 3'b111;
      s_if.w_last = 3'b111;
      m_if.w_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk("w_valid", m_if.w_valid, 1);
         chk("w_s_ready", s_if.w_ready, (k < 2) ? 3'b010 : 3'b100);
         chk("w_payload", m_if.w, (k < 2) ? wpl[1] : wpl[2]);
         chk("w_last", m_if.w_last, 1);
      end
      @(negedge clk);
      #1;
      chk("w_empty_valid", m_if.w_valid, 0);
      chk("w_empty_ready", s_if.w_ready, 0);
      s_if.w_valid = '0;

`ifndef CACHE_AXI_MUX_TRACK_EN
      // W FIFO full: fifth AW waits for a completed burst
      @(negedge clk);
      s_if.aw_id[11:8] = 4'h9;
      s_if.aw_valid = 3'b100;
      m_if.aw_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk("full_accept", s_if.aw_ready, 3'b100);
      end
      @(negedge clk);
      #1;
      chk("full_block_valid", m_if.aw_valid, 0);
      chk("full_block_ready", s_if.aw_ready, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         s_if.w_valid = 3'b100;
         s_if.w_last = (k == 3) ? 3'b100 : 3'b000;
         #1;
         chk("burst_w_valid", m_if.w_valid, 1);
         chk("burst_w_last", m_if.w_last, (k == 3) ? 1 : 0);
         chk("burst_aw_blocked", m_if.aw_valid, 0);
      end
      @(negedge clk);
      s_if.w_valid = '0;
      #1;
      chk("fifth_aw_valid", m_if.aw_valid, 1);
      chk("fifth_aw_ready", s_if.aw_ready, 3'b100);
      chk("fifth_aw_id", m_if.aw_id, 6'h29);
      @(negedge clk);
      s_if.aw_valid = '0;
      m_if.aw_ready = 1'b0;
`endif

      // reset drops queued W indices
      @(negedge clk);
      rst = 1'b1;
      s_if.w_valid = 3'b111;
      s_if.w_last = 3'b111;
      #1;
      chk("midrst_w_valid", m_if.w_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("postrst_w_valid", m_if.w_valid, 0);
      chk("postrst_w_ready", s_if.w_ready, 0);
      s_if.w_valid = '0;
      m_if.w_ready = 1'b0;

      // R/B demux and decode error
      @(negedge clk);
      m_if.r_valid = 1'b1;
      m_if.r_id = 6'b01_0011;
      m_if.r = 66'h2_0000_0000_0000_1234;
      m_if.r_last = 1'b1;
      s_if.r_ready = 3'b010;
      #1;
      chk("r_s_valid", s_if.r_valid, 3'b010);
      chk("r_s_id", s_if.r_id, 4'b0011);
      chk("r_payload", s_if.r, 66'h2_0000_0000_0000_1234);
      chk("r_m_ready", m_if.r_ready, 1);
      @(negedge clk);
      s_if.r_ready = 3'b000;
      #1;
      chk("r_backpress", m_if.r_ready, 0);
      chk("r_s_valid_bp", s_if.r_valid, 3'b010);
      @(negedge clk);
      m_if.r_id = 6'b11_0011;
      #1;
      chk("r_bad_s_valid", s_if.r_valid, 0);
      chk("r_bad_drop", m_if.r_ready, 1);
      chk("r_ok_no_err", dec_err, 0);
      @(negedge clk);
      m_if.r_valid = 1'b0;
      #1;
      chk("r_dec_err", dec_err, 1);
      @(negedge clk);
      #1;
      chk("r_dec_err_clr", dec_err, 0);
      @(negedge clk);
      m_if.b_valid = 1'b1;
      m_if.b_id = 6'b10_0001;
      m_if.b = 2'b10;
      s_if.b_ready = 3'b100;
      #1;
      chk("b_s_valid", s_if.b_valid, 3'b100);
      chk("b_s_id", s_if.b_id, 4'b0001);
      chk("b_payload", s_if.b, 2'b10);
      chk("b_m_ready", m_if.b_ready, 1);
      @(negedge clk);
      m_if.b_id = 6'b11_0001;
      m_if.r_valid = 1'b1;
      m_if.r_id = 6'b11_0000;
      s_if.b_ready = 3'b000;
      #1;
      chk("b_bad_s_valid", s_if.b_valid, 0);
      chk("b_bad_drop", m_if.b_ready, 1);
      @(negedge clk);
      m_if.r_valid = 1'b0;
      m_if.b_valid = 1'b0;
      #1;
      chk("rb_dec_err", dec_err, 1);
      @(negedge clk);
      #1;
      chk("rb_dec_err_pulse", dec_err, 0);

`ifdef CACHE_AXI_MUX_TRACK_EN
      // outstanding limit of 2 on input 0
      do_reset();
      @(negedge clk);
      s_if.ar_id = 12'h003;
      s_if.ar_valid = 3'b001;
      m_if.ar_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk("trk_ar_issue", m_if.ar_valid, 1);
      end
      @(negedge clk);
      #1;
      chk("trk_ar_blocked", m_if.ar_valid, 0);
      chk("trk_busy", busy, 3'b001);
      @(negedge clk);
      m_if.r_valid = 1'b1;
      m_if.r_id = 6'b00_0011;
      m_if.r_last = 1'b1;
      s_if.r_ready = 3'b001;
      #1;
      chk("trk_r_ready", m_if.r_ready, 1);
      chk("trk_still_blocked", m_if.ar_valid, 0);
      @(negedge clk);
      m_if.r_valid = 1'b0;
      #1;
      chk("trk_ar_resume", m_if.ar_valid, 1);
      chk("trk_ar_s_ready", s_if.ar_ready, 3'b001);
      @(negedge clk);
      s_if.ar_valid = '0;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
